// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, operation encodings and op-class helpers.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_RSVD = 3'b011,
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_t;

  // Ops whose adder carry is exposed on Cout.
  function automatic logic op_reports_cout(alu_op_t op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

  // Ops whose signed overflow is exposed on Ovf.
  function automatic logic op_reports_ovf(alu_op_t op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_adder.sv
// Full-width adder with carry-in, carry-out and signed overflow.
module alu_adder
  import alu_pkg::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] bb,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned SW = W + 1;

  logic [W:0] full;

  assign full = SW'(a) + SW'(bb) + SW'(cin);
  assign sum  = full[W-1:0];
  assign cout = full[W];
  // Overflow: operands share a sign that the result does not.
  assign ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);

endmodule

// File: rtl/alu.sv
// 32-bit ALU: combinational result/flags plus a one-cycle registered copy of Y and Zero.
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      F,
  output logic [XLEN-1:0] Y,
  output logic            Zero,
  output logic            Cout,
  output logic            Ovf,
  output logic [XLEN-1:0] YReg,
  output logic            ZeroReg
);

  alu_op_t         op;
  logic [XLEN-1:0] bb;
  logic [XLEN-1:0] sum;
  logic            add_cout;
  logic            add_ovf;
  logic            slt;

  assign op = alu_op_t'(F);
  assign bb = F[2] ? ~B : B;

  alu_adder #(.W(XLEN)) u_adder (
    .a    (A),
    .bb   (bb),
    .cin  (F[2]),
    .sum  (sum),
    .cout (add_cout),
    .ovf  (add_ovf)
  );

  // Signed less-than stays correct when A - B overflows.
  assign slt = sum[XLEN-1] ^ add_ovf;

  // Result mux; an unknown select falls through and propagates X.
  always_comb begin
    Y = {XLEN{1'bx}};
    case (op)
      ALU_AND:  Y = A & B;
      ALU_OR:   Y = A | B;
      ALU_ADD:  Y = sum;
      ALU_RSVD: Y = '0;
      ALU_ANDN: Y = A & ~B;
      ALU_ORN:  Y = A | ~B;
      ALU_SUB:  Y = sum;
      ALU_SLT:  Y = XLEN'(slt);
      default:  Y = {XLEN{1'bx}};
    endcase
  end

  always_comb begin
    Cout = 1'b0;
    Ovf  = 1'b0;
    if (op_reports_cout(op)) Cout = add_cout;
    if (op_reports_ovf(op))  Ovf  = add_ovf;
  end

  assign Zero = (Y == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      YReg    <= '0;
      ZeroReg <= 1'b0;
    end else begin
      YReg    <= Y;
      ZeroReg <= Zero;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu with a queue-based scoreboard checked on the falling edge.
module tb_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B, Y, YReg;
  logic [2:0]  F;
  logic        Zero, Cout, Ovf, ZeroReg;

  alu dut (
    .clk     (clk),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .F       (F),
    .Y       (Y),
    .Zero    (Zero),
    .Cout    (Cout),
    .Ovf     (Ovf),
    .YReg    (YReg),
    .ZeroReg (ZeroReg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] y;
    logic        zero;
    logic        cout;
    logic        ovf;
    logic [31:0] yreg;
    logic        zreg;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  localparam int MAXV = 32;
  logic [99:0] vec  [MAXV];   // {Zero, F, A, B, Y}
  logic        vrst [MAXV];
  logic [1:0]  vflg [MAXV];   // {Cout, Ovf}
  int          nv = 0;

  task automatic add(input logic rst, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] y, input logic z,
                     input logic c, input logic o);
    vec[nv]  = {z, f, a, b, y};
    vrst[nv] = rst;
    vflg[nv] = {c, o};
    nv++;
  endtask

  task automatic chk32(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s vec%0d actual=%h required=%h", nm, idx, act, req);
    end
  endtask

  task automatic chk1(input string nm, input int idx, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s vec%0d actual=%b required=%b", nm, idx, act, req);
    end
  endtask

  // Monitor: combinational outputs settle well before the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk32("Y",       e.idx, Y,       e.y);
        chk1 ("Zero",    e.idx, Zero,    e.zero);
        chk1 ("Cout",    e.idx, Cout,    e.cout);
        chk1 ("Ovf",     e.idx, Ovf,     e.ovf);
        chk32("YReg",    e.idx, YReg,    e.yreg);
        chk1 ("ZeroReg", e.idx, ZeroReg, e.zreg);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic        ez, prst, pz;
    logic [2:0]  ef;
    logic [31:0] ea, eb, ey, py;
    exp_t        e;

    //   rst  F     A             B             Y             Z     C     O
    add(1'b1, 3'd2, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0, 1'b0);
    add(1'b0, 3'd2, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b0);
    add(1'b0, 3'd2, 32'h00000002, 32'h00000002, 32'h00000004, 1'b0, 1'b0, 1'b0);
    add(1'b0, 3'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1);
    add(1'b0, 3'd6, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0);
    add(1'b0, 3'd6, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    add(1'b0, 3'd7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0);
    add(1'b0, 3'd7, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0);
    add(1'b0, 3'd7, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 3'd0, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0);
    add(1'b0, 3'd5, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 3'd4, 32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, 1'b0);
    add(1'b0, 3'd3, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 3'd1, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 3'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0);
    add(1'b0, 3'd6, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
    add(1'b1, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    add(1'b0, 3'd1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0);
    add(1'b0, 3'd2, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0);

    reset = 1'b1;
    F = 3'd0;
    A = '0;
    B = '0;
    prst = 1'b1;
    py   = '0;
    pz   = 1'b0;

    for (int i = 0; i < nv; i++) begin
      @(posedge clk);
      #1;
      if ($isunknown(vec[i])) break;
      {ez, ef, ea, eb, ey} = vec[i];
      reset = vrst[i];
      F = ef;
      A = ea;
      B = eb;
      e.idx  = i;
      e.y    = ey;
      e.zero = ez;
      e.cout = vflg[i][1];
      e.ovf  = vflg[i][0];
      e.yreg = prst ? 32'h0 : py;
      e.zreg = prst ? 1'b0 : pz;
      sb.push_back(e);
      prst = vrst[i];
      py   = ey;
      pz   = ez;
    end

    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The alu SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for the registered result stage.
REQ-003 reset  input  1  synchronous, active-high, sampled on rising clk.
REQ-004 A  input  32  operand A, two's complement where signed.
REQ-005 B  input  32  operand B, two's complement where signed.
REQ-006 F  input  3  operation select.
REQ-007 Y  output  32  combinational result.
REQ-008 Zero  output  1  combinational, 1 when Y == 32'h0.
REQ-009 Cout  output  1  combinational carry-out of the adder for F=010/110/111, else 0.
REQ-010 Ovf  output  1  combinational signed overflow for F=010/110, else 0.
REQ-011 YReg  output  32  Y registered on rising clk.
REQ-012 ZeroReg  output  1  Zero registered on rising clk.

Function
REQ-013 Bb SHALL be ~B when F[2]=1, else B; Sum = A + Bb + F[2], 33-bit, with Cout = Sum[32].
REQ-014 F=000: Y SHALL be A & B.
REQ-015 F=001: Y SHALL be A | B.
REQ-016 F=010: Y SHALL be A + B, modulo 2^32.
REQ-017 F=011: Y SHALL be 32'h0 (reserved).
REQ-018 F=100: Y SHALL be A & ~B.
REQ-019 F=101: Y SHALL be A | ~B.
REQ-020 F=110: Y SHALL be A - B, modulo 2^32.
REQ-021 F=111 (SLT): Y SHALL be 32'h1 when signed A < signed B, else 32'h0.
REQ-022 The SLT decision SHALL be Sum[31] XOR Ovf_sub, so that it stays correct when the subtraction overflows.
REQ-023 Ovf SHALL be (A[31] == Bb[31]) && (Sum[31] != A[31]).
REQ-024 Y, Zero, Cout and Ovf SHALL be purely combinational, with zero-cycle latency, and SHALL settle within half a clock period of any input change.
REQ-025 On each rising clk with reset=0, YReg SHALL take Y and ZeroReg SHALL take Zero, giving a one-cycle latency.
REQ-026 An F value that is X or Z SHALL NOT be masked: Y may propagate X.

Reset
REQ-027 While reset=1 at a rising clk, YReg SHALL become 32'h0 and ZeroReg SHALL become 0.
REQ-028 Reset SHALL NOT affect Y, Zero, Cout or Ovf.
REQ-029 After reset is released, YReg and ZeroReg SHALL track Y and Zero from the next rising edge.

Structure
REQ-030 A shared package alu_pkg SHALL hold the 3-bit typedef alu_op_t and the F encodings: ALU_AND, ALU_OR, ALU_ADD, ALU_RSVD, ALU_ANDN, ALU_ORN, ALU_SUB, ALU_SLT.
REQ-031 The package SHALL hold the constant XLEN = 32.
REQ-032 One sub-module, alu_adder, SHALL implement the 33-bit add with carry-in, Cout and Ovf.
REQ-033 The logic/compare/mux and the result register SHALL live in alu itself.
REQ-034 The reserved code 011 SHALL NOT be decoded as an arithmetic operation.

Verification
REQ-035 The bench SHALL apply vectors packed as {Zero, F, A, B, Y} (100 bits) after each rising clk, compare {Y, Zero} on the falling clk, count errors, and stop on the first all-X vector.
REQ-036 ADD: F=2, A=00000002, B=00000002 -> Y=00000004, Zero=0; F=2, A=7FFFFFFF, B=00000001 -> Y=80000000, Ovf=1.
REQ-037 SUB: F=6, A=00000000, B=00000000 -> Y=0, Zero=1; F=6, A=0, B=1 -> Y=FFFFFFFF, Zero=0.
REQ-038 SLT: F=7, A=FFFFFFFF, B=00000001 -> Y=00000001; F=7, A=80000000, B=7FFFFFFF -> Y=1 (overflow case); F=7, A=1, B=FFFFFFFF -> Y=0, Zero=1.
REQ-039 Logic: F=0, A=FFFFFFFF, B=12345678 -> Y=12345678; F=5, A=0, B=FFFFFFFF -> Y=0, Zero=1; F=4, A=FFFFFFFF, B=0000FFFF -> Y=FFFF0000; F=3 with any operands -> Y=0, Zero=1.
REQ-040 Reset and register: reset=1 for one edge -> YReg=0, ZeroReg=0; release with F=2, A=1, B=1 -> YReg=00000002 one edge later.
